// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
// State encoding and default operand width.
package serial_adder_pkg;

    localparam int WIDTH_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_SHIFT = 2'd1;
    localparam state_t S_DONE  = 2'd2;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half adders.
// The carries of both half adders are ORed together.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s1;
    logic c1;
    logic c2;

    // first half adder on the operand bits
    assign s1 = a ^ b;
    assign c1 = a & b;

    // second half adder folds in the carry
    assign s  = s1 ^ ci;
    assign c2 = s1 & ci;

    assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice, LSB first.
// WIDTH shift cycles per operation, then a done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_co;
    logic             accept;

    // a new operation may begin whenever no bits are in flight
    assign accept = start && (state != S_SHIFT);

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);
    assign cout = carry;

    full_adder u_fa (
        .a  (ra[0]),
        .b  (rb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // operand capture, shifting datapath and state sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ra    <= '0;
            rb    <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
        end else if (accept) begin
            state <= S_SHIFT;
            ra    <= a;
            rb    <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
        end else begin
            case (state)
                S_SHIFT: begin
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    carry <= fa_co;
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
